exc_flush_sequencer: RTL
========================

# exc_flush_sequencer

Multi-cycle sequencer placed between the combinational exception unit and the rest of the CPU. It accepts an exception or ERET request, stalls the pipeline until outstanding instruction and data SRAM transactions have drained, then commits to CP0 with a single-cycle flush. Finally it hands the new PC to fetch through a valid/ready handshake. This gives every exception one ordered flush/commit/redirect sequence, free of in-flight bus races.

## Interface
- OUTST_W, 2: width of the outstanding data-request counter. It saturates at 2^OUTST_W-1.
- TIMEOUT_CYC, 255: cycles allowed in DRAIN before a forced commit. Used only with EXC_DRAIN_TIMEOUT_EN.
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- exc_req  in  1  level from the exception unit's flush output.
- exc_is_eret  in  1  request is ERET (the exception unit's clean-EXL output).
- exc_code  in  5  exception code.
- exc_epc  in  32  EPC value.
- exc_new_pc  in  32  target PC.
- dbus_issue  in  1  data SRAM request accepted this cycle.
- dbus_resp  in  1  data SRAM response returned this cycle.
- ibus_busy  in  1  instruction fetch transaction in flight.
- redirect_ready  in  1  fetch accepts the redirect.
- pipe_stall  out  1  hold all pipeline stages.
- pipe_flush  out  1  one-cycle kill of all stages.
- cp0_exp_we  out  1  one-cycle exception commit strobe to CP0.
- cp0_eret_we  out  1  one-cycle ERET strobe to CP0 (clears EXL).
- cp0_exp_code  out  5  latched code.
- cp0_exp_epc  out  32  latched EPC.
- redirect_valid  out  1  new PC offered to fetch.
- redirect_pc  out  32  latched target PC.
- seq_busy  out  1  state is not IDLE.
- drain_timeout  out  1  one-cycle pulse when DRAIN is forced out.

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- **IDLE**
  - When exc_req=1: latch exc_code, exc_epc, exc_new_pc and exc_is_eret into registers, then go to DRAIN.
  - exc_req is ignored in all other states, because the stalled pipeline holds the request and COMMIT's flush kills it.
- **DRAIN**
  - Stay while outst_cnt!=0 or ibus_busy=1.
  - Otherwise go to COMMIT.
- **COMMIT** (exactly one cycle)
  - pipe_flush=1.
  - Assert cp0_exp_we=1 if the latched eret bit is 0, else cp0_eret_we=1. Never both.
  - Go to REDIRECT.
- **REDIRECT**
  - redirect_valid=1 and redirect_pc is held stable.
  - Go to IDLE on the cycle redirect_ready=1.
- **outst_cnt**, updated in every state:
  - +1 on dbus_issue alone; -1 on dbus_resp alone; unchanged when both or neither are asserted.
  - Saturates at its maximum; a decrement at 0 is ignored.
- **Combinational outputs**
  - pipe_stall = (state==IDLE & exc_req) | (state!=IDLE), so the stall is asserted in the request cycle itself.
  - cp0_exp_code and cp0_exp_epc always show the latched registers.

## Timing
- Reset value of all registers and outputs is 0: state=IDLE, outst_cnt=0, latched registers=0. Reset is asynchronous and may occur in any state; the next cycle starts from IDLE with all outputs at 0.
- Minimum latency, with a clean bus and ready held at 1:
  - exc_req at cycle 0.
  - DRAIN at cycle 1.
  - COMMIT (flush and CP0 strobe) at cycle 2.
  - REDIRECT at cycle 3.
  - IDLE at cycle 4.
- Each additional cycle of outstanding traffic or ibus_busy extends DRAIN by one cycle.
- Redirect handshake: once redirect_valid is raised, it stays high until ready is sampled at 1. redirect_pc never changes while valid is high.
- A new exc_req in the IDLE cycle immediately after REDIRECT starts a new sequence. No dead cycle is required.

## Configuration
- **EXC_DRAIN_TIMEOUT_EN defined**
  - A counter runs while in DRAIN. It clears on entry to DRAIN.
  - When it reaches TIMEOUT_CYC, DRAIN is left for COMMIT regardless of outst_cnt or ibus_busy.
  - drain_timeout pulses for one cycle and outst_cnt is cleared to 0.
- **EXC_DRAIN_TIMEOUT_EN undefined**
  - DRAIN waits indefinitely.
  - drain_timeout is tied to 0 and no timeout counter exists.

## Test plan
- Idle bus, exc_req=1 for one cycle, code=0x0C, epc=0x80001000, new_pc=0xBFC00380, ready=1:
  - pipe_flush and cp0_exp_we both at cycle 2.
  - redirect_valid at cycle 3 with pc=0xBFC00380.
  - seq_busy low at cycle 4.
- Two dbus_issue before exc_req, responses at cycles 5 and 7:
  - DRAIN holds until cycle 7; COMMIT occurs at cycle 8.
  - Simultaneous issue+resp leaves the count unchanged.
- ERET request with new_pc=epc=0x80002004:
  - cp0_eret_we=1 and cp0_exp_we=0 at COMMIT.
  - redirect_pc=0x80002004.
- redirect_ready held 0 for 3 cycles:
  - redirect_valid stays 1 and redirect_pc stays stable.
  - Return to IDLE the cycle after ready rises.
- resetn pulsed low during DRAIN with outst_cnt=2:
  - All outputs read 0 immediately.
  - A subsequent exc_req runs the minimum 4-cycle sequence.
- With EXC_DRAIN_TIMEOUT_EN and TIMEOUT_CYC=8, ibus_busy stuck at 1:
  - drain_timeout pulses after 8 DRAIN cycles, followed by COMMIT and REDIRECT.
  - Without the macro, the sequencer is still in DRAIN after 100 cycles.

Source files
------------

// File: rtl/exc_flush_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : exc_flush_sequencer_if
// Description : Request, bus-activity, CP0 and redirect signals of the
//               exception flush sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface exc_flush_sequencer_if;
    logic        exc_req;
    logic        exc_is_eret;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic [31:0] exc_new_pc;
    logic        dbus_issue;
    logic        dbus_resp;
    logic        ibus_busy;
    logic        redirect_ready;
    logic        pipe_stall;
    logic        pipe_flush;
    logic        cp0_exp_we;
    logic        cp0_eret_we;
    logic [4:0]  cp0_exp_code;
    logic [31:0] cp0_exp_epc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        seq_busy;
    logic        drain_timeout;

    // Environment side: exception unit, bus monitors and fetch
    modport master (
        output exc_req, exc_is_eret, exc_code, exc_epc, exc_new_pc,
        output dbus_issue, dbus_resp, ibus_busy, redirect_ready,
        input  pipe_stall, pipe_flush, cp0_exp_we, cp0_eret_we,
        input  cp0_exp_code, cp0_exp_epc, redirect_valid, redirect_pc,
        input  seq_busy, drain_timeout
    );

    // Sequencer side
    modport slave (
        input  exc_req, exc_is_eret, exc_code, exc_epc, exc_new_pc,
        input  dbus_issue, dbus_resp, ibus_busy, redirect_ready,
        output pipe_stall, pipe_flush, cp0_exp_we, cp0_eret_we,
        output cp0_exp_code, cp0_exp_epc, redirect_valid, redirect_pc,
        output seq_busy, drain_timeout
    );
endinterface
`default_nettype wire

// File: rtl/exc_flush_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exc_flush_sequencer
// Description : Exception/ERET sequencer: stall, drain bus traffic, commit to
//               CP0 with a one-cycle flush, then redirect fetch.
//               Optional DRAIN timeout enabled by EXC_DRAIN_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_flush_sequencer #(
    parameter int OUTST_W     = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  wire logic            clk,
    input  wire logic            resetn,
    exc_flush_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_COMMIT   = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    localparam logic [OUTST_W-1:0] c_OUTST_MAX = '1;

    state_t             r_state;
    state_t             w_next_state;
    logic [OUTST_W-1:0] r_outst;
    logic [OUTST_W-1:0] w_outst_next;
    logic [4:0]         r_code;
    logic [31:0]        r_epc;
    logic [31:0]        r_new_pc;
    logic               r_eret;
    logic               w_drained;
    logic               w_timeout;
    logic               w_pipe_flush;
    logic               w_exp_we;
    logic               w_eret_we;
    logic               w_redirect_valid;

    always_comb begin
        w_outst_next = r_outst;
        if (bus.dbus_issue && !bus.dbus_resp && (r_outst != c_OUTST_MAX)) begin
            w_outst_next = r_outst + 1'b1;
        end else if (bus.dbus_resp && !bus.dbus_issue && (r_outst != '0)) begin
            w_outst_next = r_outst - 1'b1;
        end
    end

    // A response arriving this cycle already counts as drained
    assign w_drained = (w_outst_next == '0) && !bus.ibus_busy;

`ifdef EXC_DRAIN_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt <= '0;
        end else if (r_state != S_DRAIN) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Fires in the TIMEOUT_CYC-th DRAIN cycle unless the bus drained anyway
    assign w_timeout = (r_state == S_DRAIN) && !w_drained &&
                       (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1));
`else
    // TIMEOUT_CYC has no effect without the timeout feature
    assign w_timeout = 1'b0 & (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_outst  <= '0;
            r_code   <= '0;
            r_epc    <= '0;
            r_new_pc <= '0;
            r_eret   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_outst <= w_timeout ? '0 : w_outst_next;
            if ((r_state == S_IDLE) && bus.exc_req) begin
                r_code   <= bus.exc_code;
                r_epc    <= bus.exc_epc;
                r_new_pc <= bus.exc_new_pc;
                r_eret   <= bus.exc_is_eret;
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_pipe_flush     = 1'b0;
        w_exp_we         = 1'b0;
        w_eret_we        = 1'b0;
        w_redirect_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.exc_req) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drained || w_timeout) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_pipe_flush = 1'b1;
                w_exp_we     = !r_eret;
                w_eret_we    = r_eret;
                w_next_state = S_REDIRECT;
            end
            S_REDIRECT: begin
                w_redirect_valid = 1'b1;
                if (bus.redirect_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.pipe_stall     = (r_state != S_IDLE) || bus.exc_req;
    assign bus.pipe_flush     = w_pipe_flush;
    assign bus.cp0_exp_we     = w_exp_we;
    assign bus.cp0_eret_we    = w_eret_we;
    assign bus.cp0_exp_code   = r_code;
    assign bus.cp0_exp_epc    = r_epc;
    assign bus.redirect_valid = w_redirect_valid;
    assign bus.redirect_pc    = r_new_pc;
    assign bus.seq_busy       = (r_state != S_IDLE);
    assign bus.drain_timeout  = w_timeout;

endmodule
`default_nettype wire
